vc_dispatcher: RTL and testbench

VC_DISPATCHER -- requirements
Module: vc_dispatcher

---
 rtl/vc_dispatcher.sv | 137 +++++++++++++
 tb/tb_vc_dispatcher.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/vc_dispatcher.sv
// vc_dispatcher
//   Routes each accepted upstream word to one of four virtual-channel FIFOs.
//   The target channel is the class field data_in[DATA_W-1:DATA_W-2]. If the
//   target FIFO signals almost_full when the word is accepted, the word is
//   parked in a single-entry hold register. It is released as soon as that
//   channel drains. While a word is parked, no new word is accepted, so words
//   always leave in acceptance order.
//
//   Ports
//     clk                 rising-edge clock
//     reset               synchronous, active-low reset
//     valid_in, data_in   upstream word and its valid
//     ready_out           high when a word can be accepted (IDLE state)
//     almost_full_0..3    per-channel FIFO backpressure
//     push_0..3           registered one-cycle write strobes
//     data_out            registered word that goes with the push strobe
//     cnt_0..3            saturating per-channel push counters; these exist
//                         only when the DISPATCH_CNT_EN macro is defined
module vc_dispatcher #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_out,
  input  logic              almost_full_0,
  input  logic              almost_full_1,
  input  logic              almost_full_2,
  input  logic              almost_full_3,
  output logic              push_0,
  output logic              push_1,
  output logic              push_2,
  output logic              push_3,
  output logic [DATA_W-1:0] data_out
`ifdef DISPATCH_CNT_EN
  ,
  output logic [7:0]        cnt_0,
  output logic [7:0]        cnt_1,
  output logic [7:0]        cnt_2,
  output logic [7:0]        cnt_3
`endif
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t            state_p1, state_d;
  logic [DATA_W-1:0] hold_reg, hold_d;
  logic [3:0]        push_p1, push_d;
  logic [DATA_W-1:0] data_p1, data_d;
  logic [3:0]        af;
  logic [1:0]        in_cls, hold_cls;

  assign af       = {almost_full_3, almost_full_2, almost_full_1, almost_full_0};
  assign in_cls   = data_in[DATA_W-1 -: 2];
  assign hold_cls = hold_reg[DATA_W-1 -: 2];

  // Ready is decoded from the registered state only. This keeps it free of
  // any combinational path from the almost_full inputs.
  assign ready_out = (state_p1 == IDLE);

  // Stage 0: dispatch decision from the current inputs and the held word
  always_comb begin
    state_d = state_p1;
    hold_d  = hold_reg;
    push_d  = 4'b0000;
    data_d  = data_p1;
    unique case (state_p1)
      IDLE: begin
        if (valid_in) begin
          if (!af[in_cls]) begin
            push_d[in_cls] = 1'b1;
            data_d         = data_in;
          end else begin
            hold_d  = data_in;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // Only the held word can leave. New words wait behind it because
        // ready_out is low in this state.
        if (!af[hold_cls]) begin
          push_d[hold_cls] = 1'b1;
          data_d           = hold_reg;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 1: registered strobes, output word and hold register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_p1 <= IDLE;
      hold_reg <= '0;
      push_p1  <= 4'b0000;
      data_p1  <= '0;
    end else begin
      state_p1 <= state_d;
      hold_reg <= hold_d;
      push_p1  <= push_d;
      data_p1  <= data_d;
    end
  end

  assign push_0   = push_p1[0];
  assign push_1   = push_p1[1];
  assign push_2   = push_p1[2];
  assign push_3   = push_p1[3];
  assign data_out = data_p1;

`ifdef DISPATCH_CNT_EN
  logic [7:0] cnt_p2 [4];

  // Stage 2: counters advance on each cycle in which the strobe is visible
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) cnt_p2[k] <= 8'd0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (push_p1[k]) cnt_p2[k] <= sat_inc(cnt_p2[k]);
    end
  end

  assign cnt_0 = cnt_p2[0];
  assign cnt_1 = cnt_p2[1];
  assign cnt_2 = cnt_p2[2];
  assign cnt_3 = cnt_p2[3];
`endif

endmodule

// File: tb/tb_vc_dispatcher.sv
// tb_vc_dispatcher
//   Directed bench for vc_dispatcher (DATA_W=12). A table of per-cycle
//   {inputs, expected outputs after the edge} records drives most cases.
//   Hand-written sequences cover long backpressure and the counters
//   (the counter test is built only with DISPATCH_CNT_EN).
module tb_vc_dispatcher;

  localparam int DATA_W = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              ready_out;
  logic              almost_full_0, almost_full_1, almost_full_2, almost_full_3;
  logic              push_0, push_1, push_2, push_3;
  logic [DATA_W-1:0] data_out;
`ifdef DISPATCH_CNT_EN
  logic [7:0]        cnt_0, cnt_1, cnt_2, cnt_3;
`endif

  vc_dispatcher #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .ready_out(ready_out),
    .almost_full_0(almost_full_0), .almost_full_1(almost_full_1),
    .almost_full_2(almost_full_2), .almost_full_3(almost_full_3),
    .push_0(push_0), .push_1(push_1), .push_2(push_2), .push_3(push_3),
    .data_out(data_out)
`ifdef DISPATCH_CNT_EN
    , .cnt_0(cnt_0), .cnt_1(cnt_1), .cnt_2(cnt_2), .cnt_3(cnt_3)
`endif
  );

  always #5 clk = ~clk;

  logic [3:0] push_v;
  assign push_v = {push_3, push_2, push_1, push_0};

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic              rst;
    logic              v;
    logic [DATA_W-1:0] d;
    logic [3:0]        af;
    logic [3:0]        e_push;
    logic [DATA_W-1:0] e_dout;
    logic              e_rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic v,
                              input logic [DATA_W-1:0] d, input logic [3:0] af,
                              input logic [3:0] e_push,
                              input logic [DATA_W-1:0] e_dout, input logic e_rdy);
    vec_t r;
    r.rst = rst; r.v = v; r.d = d; r.af = af;
    r.e_push = e_push; r.e_dout = e_dout; r.e_rdy = e_rdy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic [DATA_W-1:0] d,
                       input logic [3:0] af);
    @(negedge clk);
    reset = rst; valid_in = v; data_in = d;
    {almost_full_3, almost_full_2, almost_full_1, almost_full_0} = af;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_push,
                         input logic [DATA_W-1:0] e_dout, input logic e_rdy);
    chk({tag, ".push"}, {28'd0, push_v}, {28'd0, e_push});
    chk({tag, ".data_out"}, {20'd0, data_out}, {20'd0, e_dout});
    chk({tag, ".ready"}, {31'd0, ready_out}, {31'd0, e_rdy});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; valid_in = 1'b0; data_in = '0;
    {almost_full_3, almost_full_2, almost_full_1, almost_full_0} = 4'h0;

    // rst  v     data     af      push    dout     rdy
    vecs.push_back(mk(0, 1, 12'h805, 4'h0, 4'h0, 12'h000, 1)); // reset ignores valid
    vecs.push_back(mk(1, 1, 12'h805, 4'h0, 4'h4, 12'h805, 1)); // first edge after reset
    vecs.push_back(mk(1, 0, 12'h000, 4'h0, 4'h0, 12'h805, 1)); // idle keeps data_out
    vecs.push_back(mk(1, 1, 12'h011, 4'h0, 4'h1, 12'h011, 1)); // classes 0..3 back to back
    vecs.push_back(mk(1, 1, 12'h422, 4'h0, 4'h2, 12'h422, 1));
    vecs.push_back(mk(1, 1, 12'h833, 4'h0, 4'h4, 12'h833, 1));
    vecs.push_back(mk(1, 1, 12'hC44, 4'h0, 4'h8, 12'hC44, 1));
    vecs.push_back(mk(1, 1, 12'h455, 4'hD, 4'h2, 12'h455, 1)); // other channels busy
    vecs.push_back(mk(1, 1, 12'h4AA, 4'h2, 4'h0, 12'h455, 0)); // class 1 blocked -> HOLD
    vecs.push_back(mk(1, 1, 12'hC77, 4'h2, 4'h0, 12'h455, 0)); // class 3 waits behind it
    vecs.push_back(mk(1, 1, 12'hC77, 4'h0, 4'h2, 12'h4AA, 1)); // held word leaves first
    vecs.push_back(mk(1, 1, 12'hC77, 4'h0, 4'h8, 12'hC77, 1)); // then class 3
    vecs.push_back(mk(1, 0, 12'h000, 4'h0, 4'h0, 12'hC77, 1));
    vecs.push_back(mk(1, 1, 12'h9BB, 4'h4, 4'h0, 12'hC77, 0)); // class 2 parked
    vecs.push_back(mk(0, 0, 12'h000, 4'h0, 4'h0, 12'h000, 1)); // reset discards it
    vecs.push_back(mk(1, 0, 12'h000, 4'h0, 4'h0, 12'h000, 1)); // no late push
    vecs.push_back(mk(1, 1, 12'h0EE, 4'h0, 4'h1, 12'h0EE, 1));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].v, vecs[i].d, vecs[i].af);
      chk_out($sformatf("vec%0d", i), vecs[i].e_push, vecs[i].e_dout, vecs[i].e_rdy);
    end

    // Long backpressure on class 1: the word is held for 5 cycles, then released.
    drive(1, 1, 12'h4AA, 4'h2);
    chk_out("bp.accept", 4'h0, 12'h0EE, 0);
    for (int c = 0; c < 5; c++) begin
      drive(1, 0, 12'h000, 4'h2);
      chk_out($sformatf("bp.wait%0d", c), 4'h0, 12'h0EE, 0);
    end
    drive(1, 0, 12'h000, 4'h0);
    chk_out("bp.release", 4'h2, 12'h4AA, 1);
    drive(1, 0, 12'h000, 4'h0);
    chk_out("bp.after", 4'h0, 12'h4AA, 1);

`ifdef DISPATCH_CNT_EN
    drive(0, 0, 12'h000, 4'h0);
    chk({"cnt.reset"}, {24'd0, cnt_0}, 32'd0);
    for (int c = 0; c < 300; c++) drive(1, 1, 12'h001, 4'h0);
    drive(1, 0, 12'h000, 4'h0);
    drive(1, 0, 12'h000, 4'h0);
    chk("cnt_0.sat", {24'd0, cnt_0}, 32'd255);
    chk("cnt_1", {24'd0, cnt_1}, 32'd0);
    chk("cnt_2", {24'd0, cnt_2}, 32'd0);
    chk("cnt_3", {24'd0, cnt_3}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
